dpm_group_loader: RTL
=====================

Name: dpm_group_loader

Overview:
- Downstream consumer of the SFTM→DPM group FIFO.
- Pops transform-domain words from the FIFO read port, which has 1-cycle read latency.
- Assembles GROUP_WORDS words into one parallel group vector and presents it to the DPM with a valid/ready handshake.
- Checks group framing against the FIFO last flag and returns a one-cycle credit pulse upstream per group consumed.

Parameters:
- DATA_W, 16, word width.
- GROUP_WORDS, 4, words per group (16 for deconv, 12 for 3-ch conv); must be ≥2.
- CNT_W, $clog2(GROUP_WORDS+1), counter width (localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; permits starting new groups.
- flush  in  1  synchronous abort of the current group.
- fifo_empty  in  1  FIFO empty status.
- fifo_rd_en  out  1  FIFO pop request.
- fifo_rd_data  in  DATA_W  FIFO read data, valid one cycle after fifo_rd_en.
- fifo_rd_valid  in  1  read data valid.
- fifo_rd_last  in  1  group-end marker accompanying read data.
- grp_valid  out  1  assembled group available.
- grp_ready  in  1  DPM accepts the group.
- grp_data  out  DATA_W*GROUP_WORDS  word k at [k*DATA_W +: DATA_W].
- grp_frame_err  out  1  framing error for the presented group (qualified by grp_valid).
- credit_ret  out  1  one-cycle pulse, one per accepted group.
- err_sticky  out  1  sticky protocol error, cleared only by flush or reset.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including grp_data. Counters issued and recv = 0. discard_q=0.
- FSM states: IDLE, FILL, HOLD.
- IDLE → FILL when enable=1 and flush=0.
- FILL → HOLD on the cycle recv reaches GROUP_WORDS. grp_valid is registered high the next cycle.
- HOLD → FILL on grp_ready&&grp_valid if enable=1, else → IDLE.
- Dropping enable in FILL does not abort; the group completes.
- Issue rule: fifo_rd_en = (state==FILL) && !fifo_empty && (issued<GROUP_WORDS) && !flush. This is combinational. issued increments on each fifo_rd_en.
- Receive rule: fifo_rd_valid && !discard_q writes fifo_rd_data into slot recv, then recv++. Slot index comes from recv, never from issued.
- Framing check: the last flag must be 1 exactly on slot GROUP_WORDS-1 and 0 elsewhere.
  - Any mismatch sets the group's frame_err bit and err_sticky.
  - The word is still stored; counting is not resynchronised.
- Unsolicited fifo_rd_valid (recv==issued) or fifo_rd_valid in IDLE/HOLD: data is dropped and err_sticky is set.
- Best-case throughput: GROUP_WORDS+2 cycles/group (issue, 1-cycle latency, HOLD handshake). No prefetch of the next group during HOLD.
- HOLD: grp_valid, grp_data and grp_frame_err are held stable until handshake.
- On handshake:
  - grp_valid deasserts the next cycle.
  - issued/recv and frame_err clear.
  - credit_ret pulses high for exactly one cycle, the cycle after handshake.
- Empty gaps: fifo_empty stalls issue with no penalty beyond the gap. Words remain in order.
- flush (any state), next cycle:
  - state=IDLE; counters, grp_valid and frame_err cleared; err_sticky cleared.
  - No credit_ret.
  - discard_q=1 for one cycle, dropping an in-flight read returned from a pop issued the flush cycle or the cycle before.
  - Flush has priority over handshake in the same cycle.
- Simultaneous flush and enable: flush wins; IDLE is held for at least one cycle.
- Reset mid-group: everything returns to reset values immediately. Partial data is lost and no credit is issued.

Decomposition:
- Package group_pkg:
  - DATA_W and GROUP_WORDS defaults, shared with the SFTM and the group FIFO.
  - GROUP_WORDS_DECONV=16 and GROUP_WORDS_CONV3=12 constants.
  - loader_state_t enum {IDLE, FILL, HOLD}.
- No sub-module. A single always block for the FSM and counters, plus a slot-write loop.

Test Plan:
- Basic group, GROUP_WORDS=4, FIFO preloaded 0x11,0x22,0x33,0x44 with last on word 3, grp_ready=1 → four consecutive fifo_rd_en. Then grp_valid for one cycle with grp_data=0x0044_0033_0022_0011, grp_frame_err=0, and credit_ret pulsing once the following cycle.
- Back-pressure: grp_ready=0 for 10 cycles → grp_valid and grp_data stable for all 10 cycles, no extra fifo_rd_en, credit_ret only after grp_ready rises.
- Framing error: last asserted on word 1 → group presented with grp_frame_err=1 and err_sticky=1. The next correct group gives grp_frame_err=0 while err_sticky stays 1 until flush.
- Empty gaps: fifo_empty high for 3 cycles between words 1 and 2 → fifo_rd_en suppressed during the gap, data order preserved, group completes correctly.
- Flush mid-group: flush after 2 pops with one read in flight → in-flight word discarded, no credit_ret, busy=0. The next group assembles from fresh words with no stale slot contents.
- Reset mid-HOLD: rst_n low while grp_valid=1 → grp_valid, credit_ret and err_sticky go to 0 asynchronously and the FSM restarts from IDLE.

Source files
------------

// File: rtl/group_pkg.sv
// Shared definitions for the SFTM -> group FIFO -> DPM path.
package group_pkg;

  // Defaults shared by the SFTM, the group FIFO and the loader.
  localparam int DATA_W_DEF         = 16;
  localparam int GROUP_WORDS_DEF    = 4;

  // Group sizes used by the two supported layer types.
  localparam int GROUP_WORDS_DECONV = 16;
  localparam int GROUP_WORDS_CONV3  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

endpackage

// File: rtl/dpm_group_loader.sv
// Pops GROUP_WORDS words from the group FIFO (1-cycle read latency), packs
// them into one parallel vector for the DPM, checks framing against the
// FIFO last flag and returns one credit pulse per group consumed.
module dpm_group_loader
  import group_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int GROUP_WORDS = GROUP_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [DATA_W-1:0]             fifo_rd_data,
  input  logic                          fifo_rd_valid,
  input  logic                          fifo_rd_last,
  output logic                          grp_valid,
  input  logic                          grp_ready,
  output logic [DATA_W*GROUP_WORDS-1:0] grp_data,
  output logic                          grp_frame_err,
  output logic                          credit_ret,
  output logic                          err_sticky,
  output logic                          busy
);

  localparam int                CNT_W     = $clog2(GROUP_WORDS + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(GROUP_WORDS);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(GROUP_WORDS - 1);

  loader_state_t                   r_state;
  loader_state_t                   w_state_nxt;
  logic [CNT_W-1:0]                r_issued;
  logic [CNT_W-1:0]                r_recv;
  logic                            r_grp_valid;
  logic                            r_frame_err;
  logic                            r_err_sticky;
  logic                            r_credit;
  logic                            r_discard;
  logic [DATA_W*GROUP_WORDS-1:0]   r_grp_data;

  logic w_accept;
  logic w_stray;
  logic w_last_word;
  logic w_frame_bad;
  logic w_handshake;

  // Pop only while filling, with room left in the group and no abort pending.
  assign fifo_rd_en  = (r_state == FILL) && !fifo_empty && (r_issued < FULL_CNT) && !flush;

  // A returning word is ours only if a pop is outstanding (recv trails issued).
  assign w_accept    = (r_state == FILL) && fifo_rd_valid && !r_discard && !flush
                       && (r_recv != r_issued);
  assign w_stray     = fifo_rd_valid && !r_discard && !flush && !w_accept;
  assign w_last_word = w_accept && (r_recv == LAST_SLOT);
  assign w_frame_bad = w_accept && (fifo_rd_last != (r_recv == LAST_SLOT));
  assign w_handshake = r_grp_valid && grp_ready && !flush;

  assign grp_valid     = r_grp_valid;
  assign grp_data      = r_grp_data;
  assign grp_frame_err = r_grp_valid & r_frame_err;
  assign credit_ret    = r_credit;
  assign err_sticky    = r_err_sticky;
  assign busy          = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything, including a handshake.
  always_comb begin
    // NOTE: default first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (enable)      w_state_nxt = FILL;
        FILL:    if (w_last_word) w_state_nxt = HOLD;
        HOLD:    if (w_handshake) w_state_nxt = enable ? FILL : IDLE;
        default:                  w_state_nxt = IDLE;
      endcase
    end
  end

  // Counters, presentation flags, error tracking, credit and discard window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued     <= '0;
      r_recv       <= '0;
      r_grp_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_credit     <= 1'b0;
      r_discard    <= 1'b0;
    end else if (flush) begin
      r_issued     <= '0;
      r_recv       <= '0;
      r_grp_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_credit     <= 1'b0;
      r_discard    <= 1'b1;
    end else begin
      r_discard <= 1'b0;
      r_credit  <= w_handshake;
      if (fifo_rd_en)               r_issued     <= r_issued + CNT_W'(1);
      if (w_accept)                 r_recv       <= r_recv + CNT_W'(1);
      if (w_frame_bad)              r_frame_err  <= 1'b1;
      if (w_frame_bad || w_stray)   r_err_sticky <= 1'b1;
      if (w_last_word)              r_grp_valid  <= 1'b1;
      if (w_handshake) begin
        r_issued    <= '0;
        r_recv      <= '0;
        r_frame_err <= 1'b0;
        r_grp_valid <= 1'b0;
      end
    end
  end

  // Slot write: each accepted word lands in the slot named by recv.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the slot store is reset because grp_data is a visible output that
    // must read zero out of reset; a flush leaves it alone since every slot is
    // rewritten before the next group is presented.
    if (!rst_n) begin
      r_grp_data <= '0;
    end else begin
      for (int k = 0; k < GROUP_WORDS; k++) begin
        if (w_accept && (r_recv == CNT_W'(k)))
          r_grp_data[k*DATA_W +: DATA_W] <= fifo_rd_data;
      end
    end
  end

endmodule
